// File: rtl/apb_master.sv
// apb_master: single-channel APB4-subset requester.
// A 2-bit command (00/10 idle, 01 read, 11 write) drives the IDLE -> SETUP -> ACCESS
// sequence. Addresses come from an auto-incrementing counter, and write data is the
// most recently captured read data, so a read followed by a write copies a location
// to the next address.
module apb_master #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
    input  logic              pclk,
    input  logic              presetn,   // synchronous, active-high despite the name
    input  logic [1:0]        add,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_psel;
    logic                r_penable;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;

    // add[0] distinguishes a real command (01, 11) from idle/reserved (00, 10)
    logic                w_cmd_valid;
    logic                w_done;
    logic [ADDR_W-1:0]   w_cnt_inc;
    logic [DATA_W-1:0]   w_data_done;

    assign w_cmd_valid = add[0];
    assign w_done      = (r_state == ST_ACCESS) && pready;
    assign w_cnt_inc   = r_addr_cnt + 1'b1;
    // At a read completion the freshly returned word is what a back-to-back write must send
    assign w_data_done = r_pwrite ? r_data : prdata;

    // Protocol sequencer with registered APB outputs
    always_ff @(posedge pclk) begin
        if (presetn) begin
            r_state    <= ST_IDLE;
            r_addr_cnt <= START_ADDR;
            r_data     <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    if (w_cmd_valid) begin
                        r_state  <= ST_SETUP;
                        r_psel   <= 1'b1;
                        r_paddr  <= r_addr_cnt;
                        r_pwrite <= add[1];
                        if (add[1]) begin
                            r_pwdata <= r_data;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    // pready=0 holds every output; only a completion edge moves on
                    if (w_done) begin
                        r_data     <= w_data_done;
                        r_addr_cnt <= w_cnt_inc;
                        r_penable  <= 1'b0;
                        if (w_cmd_valid) begin
                            r_state  <= ST_SETUP;
                            r_psel   <= 1'b1;
                            r_paddr  <= w_cnt_inc;
                            r_pwrite <= add[1];
                            if (add[1]) begin
                                r_pwdata <= w_data_done;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_psel  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign psel    = r_psel;
    assign penable = r_penable;
    assign paddr   = r_paddr;
    assign pwrite  = r_pwrite;
    assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: reset, single read, wait states, read-then-write copy,
// back-to-back reads (plus a second instance near 0xFF for wrap), reset mid-transfer.
module tb_apb_master;

    logic       pclk;
    logic       presetn;
    logic [1:0] add;
    logic [7:0] prdata;
    logic       pready;

    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       psel2, penable2, pwrite2;
    logic [7:0] paddr2, pwdata2;

    int tests_run;
    int tests_failed;

    apb_master #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'h00)) dut (
        .pclk(pclk), .presetn(presetn), .add(add),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    apb_master #(.ADDR_W(8), .DATA_W(8), .START_ADDR(8'hFE)) dut_wrap (
        .pclk(pclk), .presetn(presetn), .add(add),
        .psel(psel2), .penable(penable2), .paddr(paddr2), .pwrite(pwrite2), .pwdata(pwdata2),
        .prdata(prdata), .pready(pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // penable must never be high without psel
    always @(negedge pclk) begin
        if (penable === 1'b1) check("inv_penable_psel", {31'd0, psel}, 32'd1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        presetn = 1'b1;
        add     = 2'b11;
        pready  = 1'b1;
        prdata  = 8'h00;

        // Reset held for three edges with a write command pending
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_psel",    {31'd0, psel},    32'd0);
            check("rst_penable", {31'd0, penable}, 32'd0);
            check("rst_paddr",   {24'd0, paddr},   32'h00);
            check("rst_pwdata",  {24'd0, pwdata},  32'h00);
        end
        check("rst_pwrite", {31'd0, pwrite}, 32'd0);

        // Single read of 0x32 at 0x00
        presetn = 1'b0;
        add     = 2'b01;
        prdata  = 8'h32;
        tick();
        $display("[TB] read setup  paddr=%02h", paddr);
        check("rd_setup_psel",    {31'd0, psel},    32'd1);
        check("rd_setup_penable", {31'd0, penable}, 32'd0);
        check("rd_setup_paddr",   {24'd0, paddr},   32'h00);
        check("rd_setup_pwrite",  {31'd0, pwrite},  32'd0);
        add = 2'b00;
        tick();
        check("rd_access_penable", {31'd0, penable}, 32'd1);
        check("rd_access_psel",    {31'd0, psel},    32'd1);
        tick();
        check("rd_idle_psel",    {31'd0, psel},    32'd0);
        check("rd_idle_penable", {31'd0, penable}, 32'd0);

        // Write copies 0x32 to the next address
        add = 2'b11;
        tick();
        $display("[TB] write setup paddr=%02h pwdata=%02h", paddr, pwdata);
        check("wr_setup_paddr",  {24'd0, paddr},  32'h01);
        check("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
        check("wr_setup_pwdata", {24'd0, pwdata}, 32'h32);
        add = 2'b00;
        tick();
        check("wr_access_penable", {31'd0, penable}, 32'd1);
        tick();
        check("wr_idle_psel", {31'd0, psel}, 32'd0);

        // Read at 0x02 with three wait states; only the ready edge captures
        add    = 2'b01;
        pready = 1'b0;
        prdata = 8'hEE;
        tick();
        check("ws_setup_paddr", {24'd0, paddr}, 32'h02);
        add = 2'b11;   // ignored during SETUP and waits
        tick();
        check("ws_access_penable", {31'd0, penable}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_wait_penable", {31'd0, penable}, 32'd1);
            check("ws_wait_paddr",   {24'd0, paddr},   32'h02);
            check("ws_wait_pwrite",  {31'd0, pwrite},  32'd0);
        end
        add    = 2'b00;
        pready = 1'b1;
        prdata = 8'h5A;
        tick();
        $display("[TB] wait-state read done psel=%0b", psel);
        check("ws_done_psel", {31'd0, psel}, 32'd0);
        prdata = 8'hEE;
        add    = 2'b11;
        tick();
        $display("[TB] write setup paddr=%02h pwdata=%02h", paddr, pwdata);
        check("ws_wr_paddr",  {24'd0, paddr},  32'h03);
        check("ws_wr_pwdata", {24'd0, pwdata}, 32'h5A);
        add = 2'b00;
        tick();
        tick();
        check("ws_wr_idle", {31'd0, psel}, 32'd0);

        // Back-to-back reads from a fresh reset; second instance wraps FE,FF,00,...
        presetn = 1'b1;
        tick();
        presetn = 1'b0;
        add     = 2'b01;
        for (int i = 0; i < 6; i++) begin
            prdata = 8'h10 + 8'(i);
            tick();
            $display("[TB] b2b #%0d setup paddr=%02h wrap_paddr=%02h", i, paddr, paddr2);
            check("b2b_setup_psel",    {31'd0, psel},    32'd1);
            check("b2b_setup_penable", {31'd0, penable}, 32'd0);
            check("b2b_setup_paddr",   {24'd0, paddr},   32'(i));
            check("b2b_wrap_paddr",    {24'd0, paddr2},  32'((8'hFE + 8'(i)) & 8'hFF));
            tick();
            check("b2b_access_psel",    {31'd0, psel},    32'd1);
            check("b2b_access_penable", {31'd0, penable}, 32'd1);
            check("b2b_access_paddr",   {24'd0, paddr},   32'(i));
            if (i == 5) add = 2'b00;
        end
        tick();
        check("b2b_end_psel", {31'd0, psel}, 32'd0);

        // Reset during an ACCESS wait state
        add    = 2'b01;
        pready = 1'b0;
        prdata = 8'h77;
        tick();
        check("mr_setup_paddr", {24'd0, paddr}, 32'h06);
        add = 2'b00;
        tick();
        check("mr_access_penable", {31'd0, penable}, 32'd1);
        presetn = 1'b1;
        pready  = 1'b1;
        tick();
        $display("[TB] mid-transfer reset psel=%0b paddr=%02h", psel, paddr);
        check("mr_rst_psel",    {31'd0, psel},    32'd0);
        check("mr_rst_penable", {31'd0, penable}, 32'd0);
        check("mr_rst_paddr",   {24'd0, paddr},   32'h00);
        check("mr_rst_pwrite",  {31'd0, pwrite},  32'd0);
        presetn = 1'b0;
        add     = 2'b11;
        tick();
        $display("[TB] post-reset write paddr=%02h pwdata=%02h", paddr, pwdata);
        check("mr_wr_paddr",  {24'd0, paddr},  32'h00);
        check("mr_wr_pwdata", {24'd0, pwdata}, 32'h00);
        add = 2'b00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-channel AMBA APB (APB4 subset) requester, 8-bit address and 8-bit data.
- A 2-bit command input `add` selects idle, read or write. The block sequences the standard IDLE -> SETUP -> ACCESS protocol toward one APB completer.
- Addresses come from an internal auto-incrementing counter.
- Write data is the most recently captured read data, so a read followed by a write copies a location to the next address.

Parameters:
- ADDR_W, 8, width of paddr and of the internal address counter.
- DATA_W, 8, width of pwdata/prdata and of the internal data register.
- START_ADDR, 8'h00, value loaded into the address counter on reset.

Ports:
- pclk  input  1  clock; all state changes on the rising edge.
- presetn  input  1  reset, synchronous, active-high; port keeps the codebase name presetn.
- add  input  2  command: 00 idle, 01 read, 11 write, 10 reserved (treated as idle).
- psel  output  1  APB select.
- penable  output  1  APB enable (ACCESS phase).
- paddr  output  ADDR_W  APB address.
- pwrite  output  1  1 = write, 0 = read.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data from the completer.
- pready  input  1  completer ready / wait-state insertion.

Behaviour:
Reset:
- presetn=1 sampled at a rising edge sets state=IDLE.
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- Address counter = START_ADDR; data register = 0.
- Reset overrides everything, including mid-transfer. There is no completion and no counter increment on that edge.

State machine (IDLE, SETUP, ACCESS), all outputs registered:
- IDLE:
  - psel=0, penable=0; paddr, pwrite and pwdata hold their last values.
  - add=01 or 11 -> SETUP.
  - add=00 or 10 -> stay in IDLE.
- Entering SETUP:
  - psel=1, penable=0.
  - paddr = address counter.
  - pwrite = add[1], with add captured at that edge.
  - On a write, pwdata = data register. On a read, pwdata holds its old value.
- SETUP -> ACCESS unconditionally after one cycle.
  - penable=1; psel, paddr, pwrite and pwdata unchanged.
- ACCESS with pready=0 (wait state): stay in ACCESS; every output held stable.
- ACCESS with pready=1 (completion at that edge):
  - A read loads prdata into the data register.
  - The address counter increments by 1, wrapping 0xFF -> 0x00.
  - Next state is then chosen from add sampled at this same edge:
    - If add=01 or 11, go to SETUP for a back-to-back transfer. penable=0, psel stays 1, and the new paddr, pwrite and pwdata are loaded.
    - Otherwise go to IDLE with psel=0 and penable=0.
- Changes on add during SETUP or during ACCESS wait states are ignored.
- The command is sampled only in IDLE and at a completion edge.

Timing:
- Minimum transfer = 2 cycles (SETUP + ACCESS).
- First SETUP cycle begins one edge after a valid command is seen in IDLE.
- Each pready=0 cycle in ACCESS adds one cycle.
- Continuous commands give one transfer every 2 cycles with psel held high.

Protocol invariants:
- penable=1 only when psel=1.
- penable is never high for two consecutive transfers without an intervening SETUP cycle.

Test Plan:
- Reset check: hold presetn=1 for 3 edges with add=11, pready=1 -> psel=0, penable=0, paddr=0x00, pwdata=0x00 throughout.
- Single read: release reset, prdata=0x32, pready=1, add=01 for exactly 1 IDLE cycle, then add=00.
  - Expected: SETUP cycle with psel=1, penable=0, paddr=0x00, pwrite=0.
  - Then ACCESS with penable=1.
  - Then IDLE; data register = 0x32 and the next paddr will be 0x01.
- Wait states: read with pready=0 for 3 ACCESS cycles, then 1 -> ACCESS lasts 4 cycles with paddr and pwrite stable; prdata is captured only on the pready=1 edge.
- Read then write: after the read of 0x32 at 0x00, set add=11 -> SETUP with paddr=0x01, pwrite=1, pwdata=0x32; completion advances the counter to 0x02.
- Back-to-back: hold add=01 with pready=1 for 6 transfers -> psel stays 1, penable toggles 0/1 every cycle, and paddr steps 0x00..0x05. Include a counter preloaded near 0xFF to check wrap to 0x00.
- Reset mid-transfer: assert presetn during ACCESS with pready=0 -> next edge outputs go to reset values, the counter returns to START_ADDR, and no capture or increment occurs.
